// File: rtl/pipe_pkg.sv
// Shared widths, command codes, FSM states and the saturation helper for pipe_mac.
package pipe_pkg;

    localparam int unsigned W    = 16;
    localparam int unsigned FRAC = 8;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_MAC = 4'd1;
    localparam logic [3:0] CMD_CLR = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC
    } state_t;

    // Clamp a wide signed sum into the signed W-bit range.
    function automatic logic [W-1:0] sat16(input logic signed [2*W-1:0] x);
        logic signed [2*W-1:0] max_v;
        logic signed [2*W-1:0] min_v;
        max_v = (2*W)'(32767);
        min_v = -(2*W)'(32768);
        if (x > max_v) begin
            return {1'b0, {(W-1){1'b1}}};
        end else if (x < min_v) begin
            return {1'b1, {(W-1){1'b0}}};
        end else begin
            return x[W-1:0];
        end
    endfunction

endpackage

// File: rtl/seq_mult16.sv
// 16-cycle signed shift-add multiplier: magnitude multiply, sign applied on the output.
module seq_mult16
    import pipe_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    logic           busy_q, busy_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   mag_a_q, mag_a_d;
    logic [W-1:0]   mag_b_q, mag_b_d;
    logic [2*W-1:0] prod_q, prod_d;

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        prod_d  = prod_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            neg_d   = a[W-1] ^ b[W-1];
            // 0x8000 negates to itself, which is the correct unsigned magnitude.
            mag_a_d = a[W-1] ? -a : a;
            mag_b_d = b[W-1] ? -b : b;
            prod_d  = '0;
        end else if (busy_q) begin
            if (mag_b_q[cnt_q]) begin
                prod_d = prod_q + ({{W{1'b0}}, mag_a_q} << cnt_q);
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(W-1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            prod_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            prod_q  <= prod_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == 4'(W-1));
    assign p    = neg_q ? -prod_q : prod_q;

endmodule

// File: rtl/pipe_mac.sv
// Signed Q8.8 multiply-accumulate: command decode, control FSM and saturating accumulator.
module pipe_mac
    import pipe_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   wrAddr,
    output logic [W-1:0] result
);

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           mul_start;
    logic           mul_busy;
    logic           mul_done;
    logic [2*W-1:0] mul_p;
    logic           clr;
    logic signed [2*W-1:0] acc_ext;
    logic signed [2*W-1:0] prod_sh;
    logic signed [2*W-1:0] sum;

    assign clr = (wrAddr == CMD_CLR);

    seq_mult16 u_mult (
        .clk   (clk),
        .rst_n (reset),
        .start (mul_start),
        .abort (clr),
        .a     (A),
        .b     (B),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    // Arithmetic shift drops the fraction toward -inf; high product bits stay for saturation.
    assign acc_ext = {{W{acc_q[W-1]}}, acc_q};
    assign prod_sh = $signed(mul_p) >>> FRAC;
    assign sum     = acc_ext + prod_sh;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mul_start = 1'b0;
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wrAddr == CMD_MAC) begin
                        mul_start = 1'b1;
                        state_d   = MUL;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state_d = ACC;
                    end else if (!mul_busy) begin
                        state_d = IDLE;
                    end
                end
                ACC: begin
                    acc_d   = sat16(sum);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    assign result = acc_q;

endmodule

// File: tb/tb_pipe_mac.sv
// Directed bench for pipe_mac with hand-computed Q8.8 results.
module tb_pipe_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  wrAddr;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;

    logic [15:0] da   [10] = '{16'h0140, 16'h0280, 16'h0280, 16'h0200, 16'h0300,
                               16'h0200, 16'h0140, 16'h0380, 16'h0480, 16'h0200};
    logic [15:0] db   [10] = '{16'h0180, 16'h0180, 16'h0500, 16'h0200, 16'h0500,
                               16'h0300, 16'h0380, 16'h0500, 16'h0400, 16'h0300};
    logic [15:0] dexp [10] = '{16'h01E0, 16'h05A0, 16'h1220, 16'h1620, 16'h2520,
                               16'h2B20, 16'h2F80, 16'h4100, 16'h5300, 16'h5900};

    pipe_mac dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .wrAddr (wrAddr),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (result === exp) else begin
            errors++;
            $error("FAIL %s: result=%h expected=%h", tag, result, exp);
        end
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b);
        wrAddr = cmd;
        A      = a;
        B      = b;
        tick();
        wrAddr = 4'd0;
        A      = 16'($urandom);
        B      = 16'($urandom);
    endtask

    // Load edge is E0; old value must survive E16, new value appears after E17.
    task automatic mac(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] prev, input logic [15:0] exp, input string tag);
        issue(4'd1, a, b);
        repeat (16) tick();
        check({tag, " pre"}, prev);
        tick();
        check(tag, exp);
        tick();
    endtask

    initial begin
        reset  = 1'b0;
        wrAddr = 4'd0;
        A      = '0;
        B      = '0;
        repeat (3) tick();
        check("reset", 16'h0000);
        reset = 1'b1;
        repeat (5) tick();
        check("nop idle", 16'h0000);
        issue(4'd3, 16'h0100, 16'h0100);
        issue(4'd15, 16'h0100, 16'h0100);
        repeat (20) tick();
        check("nop codes", 16'h0000);

        issue(4'd2, 16'h0000, 16'h0000);
        mac(16'h0140, 16'h0180, 16'h0000, 16'h01E0, "single");
        repeat (30) tick();
        check("hold", 16'h01E0);

        issue(4'd2, 16'h0000, 16'h0000);
        check("clear", 16'h0000);
        for (int i = 0; i < 10; i++) begin
            mac(da[i], db[i], (i == 0) ? 16'h0000 : dexp[i-1], dexp[i], $sformatf("dot%0d", i));
            repeat (44) tick();
        end
        mac(16'h0000, 16'h0000, 16'h5900, 16'h5900, "zero0");
        mac(16'h0000, 16'h0000, 16'h5900, 16'h5900, "zero1");

        issue(4'd2, 16'h0000, 16'h0000);
        mac(16'hFF00, 16'h0200, 16'h0000, 16'hFE00, "neg");
        mac(16'h7F00, 16'h7F00, 16'hFE00, 16'h7FFF, "satpos");
        issue(4'd2, 16'h0000, 16'h0000);
        mac(16'h8000, 16'h7F00, 16'h0000, 16'h8000, "satneg");
        issue(4'd2, 16'h0000, 16'h0000);
        mac(16'hFFFF, 16'h0080, 16'h0000, 16'hFFFF, "floor");

        issue(4'd2, 16'h0000, 16'h0000);
        mac(16'h0140, 16'h0180, 16'h0000, 16'h01E0, "pre-abort");
        issue(4'd1, 16'h0100, 16'h0100);
        repeat (4) tick();
        issue(4'd2, 16'h0000, 16'h0000);
        check("abort", 16'h0000);
        repeat (25) tick();
        check("abort late", 16'h0000);

        issue(4'd1, 16'h0100, 16'h0100);
        repeat (16) tick();
        issue(4'd2, 16'h0000, 16'h0000);
        check("clr over acc", 16'h0000);
        repeat (20) tick();
        check("clr over acc late", 16'h0000);

        issue(4'd1, 16'h0100, 16'h0100);
        repeat (4) tick();
        issue(4'd1, 16'h0200, 16'h0200);
        repeat (10) tick();
        tick();
        check("ignored load pre", 16'h0000);
        tick();
        check("ignored load", 16'h0100);
        repeat (30) tick();
        check("ignored load late", 16'h0100);

        issue(4'd1, 16'h0300, 16'h0200);
        repeat (7) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid reset", 16'h0000);
        repeat (25) tick();
        check("mid reset late", 16'h0000);
        mac(16'h0140, 16'h0180, 16'h0000, 16'h01E0, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
